// File: rtl/udp_payload_extract.sv
// Validates IPv4/UDP headers on a 64-bit realigned IP stream, filters on UDP destination
// port, and re-packs the UDP payload so payload byte 0 lands in dout[63:56].
module udp_payload_extract #(
    parameter logic [15:0] UDP_PORT = 16'd26400,
    parameter int          DATA_W   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   din_keep,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic [DATA_W-1:0]     dout,
    output logic [DATA_W/8-1:0]   dout_keep,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  pkt_accept,
    output logic                  pkt_drop,
    output logic [15:0]           drop_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR1    = 3'd1;
    localparam logic [2:0] S_HDR2    = 3'd2;
    localparam logic [2:0] S_HDR3    = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;
    localparam logic [2:0] S_DROP    = 3'd6;

    logic [2:0]          state_q, state_d;
    logic                ok0_q, ok0_d;
    logic                ok1_q, ok1_d;
    logic [31:0]         hold_q, hold_d;
    logic [3:0]          hold_keep_q, hold_keep_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W/8-1:0] dout_keep_q, dout_keep_d;
    logic                dout_valid_q, dout_valid_d;
    logic                dout_last_q, dout_last_d;
    logic                accept_q, accept_d;
    logic                drop_q, drop_d;
    logic [15:0]         drop_count_q, drop_count_d;
    logic                port_ok;
    logic                beat0;

    assign port_ok = (din[15:0] == UDP_PORT);
    // FLUSH emits its tail beat while simultaneously accepting beat 0 of the next packet
    assign beat0   = din_valid && (state_q == S_IDLE || state_q == S_FLUSH);

    always_comb begin
        state_d      = state_q;
        ok0_d        = ok0_q;
        ok1_d        = ok1_q;
        hold_d       = hold_q;
        hold_keep_d  = hold_keep_q;
        dout_d       = dout_q;
        dout_keep_d  = dout_keep_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        accept_d     = 1'b0;
        drop_d       = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_HDR1: begin
                if (din_valid) begin
                    ok1_d = (din[55:48] == 8'h11);
                    if (din_last) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HDR2;
                    end
                end
            end
            S_HDR2: begin
                // A passing beat that is also last leaves the UDP header truncated: drop it
                if (din_valid) begin
                    if (ok0_q && ok1_q && port_ok && !din_last) begin
                        accept_d = 1'b1;
                        state_d  = S_HDR3;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = din_last ? S_IDLE : S_DROP;
                    end
                end
            end
            S_HDR3: begin
                if (din_valid) begin
                    hold_d      = din[31:0];
                    hold_keep_d = din_keep[3:0];
                    if (!din_last) begin
                        state_d = S_PAYLOAD;
                    end else if (din_keep[3:0] != 4'h0) begin
                        state_d = S_FLUSH;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (din_valid) begin
                    dout_d       = {hold_q, din[63:32]};
                    dout_keep_d  = {hold_keep_q, din_keep[7:4]};
                    dout_valid_d = 1'b1;
                    hold_d       = din[31:0];
                    hold_keep_d  = din_keep[3:0];
                    if (din_last) begin
                        if (din_keep[3:0] == 4'h0) begin
                            dout_last_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                dout_d       = {hold_q, 32'h0};
                dout_keep_d  = {hold_keep_q, 4'h0};
                dout_valid_d = 1'b1;
                dout_last_d  = 1'b1;
                state_d      = S_IDLE;
            end
            S_DROP: begin
                if (din_valid && din_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (beat0) begin
            ok0_d = (din[63:56] == 8'h45);
            if (din_last) begin
                drop_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_HDR1;
            end
        end

        drop_count_d = drop_count_q;
        if (drop_d && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ok0_q        <= 1'b0;
            ok1_q        <= 1'b0;
            hold_q       <= '0;
            hold_keep_q  <= '0;
            dout_q       <= '0;
            dout_keep_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            accept_q     <= 1'b0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ok0_q        <= ok0_d;
            ok1_q        <= ok1_d;
            hold_q       <= hold_d;
            hold_keep_q  <= hold_keep_d;
            dout_q       <= dout_d;
            dout_keep_q  <= dout_keep_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            accept_q     <= accept_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign dout       = dout_q;
    assign dout_keep  = dout_keep_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign pkt_accept = accept_q;
    assign pkt_drop   = drop_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_udp_payload_extract.sv
// Directed table-driven bench for udp_payload_extract: packet vectors with expected
// accept/drop decisions and payload bytes, plus back-to-back, reset and saturation sequences.
module tb_udp_payload_extract;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] din;
    logic [7:0]  din_keep;
    logic        din_valid;
    logic        din_last;
    logic [63:0] dout;
    logic [7:0]  dout_keep;
    logic        dout_valid;
    logic        dout_last;
    logic        pkt_accept;
    logic        pkt_drop;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    udp_payload_extract #(.UDP_PORT(16'd26400), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_keep(din_keep), .din_valid(din_valid), .din_last(din_last),
        .dout(dout), .dout_keep(dout_keep), .dout_valid(dout_valid), .dout_last(dout_last),
        .pkt_accept(pkt_accept), .pkt_drop(pkt_drop), .drop_count(drop_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    logic [7:0] obytes[$];
    int nidx = 0, nacc = 0, ndrop = 0, nlast = 0, keep_bad = 0;
    int acc_n = -1, drop_n = -1, last_out_n = -1;

    always @(negedge clk) begin
        if (dout_valid) begin
            automatic bit seen_zero = 1'b0;
            if (dout_keep == 8'h00) keep_bad++;
            for (int k = 0; k < 8; k++) begin
                if (dout_keep[7-k]) begin
                    if (seen_zero) keep_bad++;
                    obytes.push_back(dout[63-8*k -: 8]);
                end else begin
                    seen_zero = 1'b1;
                end
            end
            if (dout_last) begin
                nlast++;
                last_out_n = nidx;
            end
        end
        if (pkt_accept) begin nacc++;  acc_n  = nidx; end
        if (pkt_drop)   begin ndrop++; drop_n = nidx; end
        nidx++;
    end

    logic [7:0] pkt[0:127];
    int beat_n[0:31];
    int last_in_n;

    task automatic build(input int len, input logic [15:0] port, input logic [7:0] proto,
                         input logic [7:0] ver, input int seed);
        for (int i = 0; i < len; i++) pkt[i] = 8'(seed + i * 13 + 1);
        pkt[0]  = ver;
        pkt[9]  = proto;
        pkt[22] = port[15:8];
        pkt[23] = port[7:0];
    endtask

    task automatic send(input int len, input bit gap, input bit idle_after, input int nbmax);
        int nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb && b < nbmax; b++) begin
            din = '0;
            din_keep = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < len) begin
                    din[63-8*k -: 8] = pkt[b*8+k];
                    din_keep[7-k]    = 1'b1;
                end
            end
            din_valid = 1'b1;
            din_last  = (b == nb - 1);
            @(posedge clk); #1;
            beat_n[b] = nidx;
            if (gap) begin
                din_valid = 1'b0;
                din_last  = 1'b0;
                @(posedge clk); #1;
            end
        end
        last_in_n = beat_n[nb-1];
        din_valid = 1'b0;
        din_last  = 1'b0;
        if (idle_after) repeat (4) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        int          len;
        logic [15:0] port;
        logic [7:0]  proto;
        logic [7:0]  ver;
        bit          gap;
        int          acc;
        int          drp;
        int          dbeat;
        int          nbytes;
        int          flush;
    } vec_t;

    vec_t vt[13];

    int ob0, acc0, drop0, last0, kb0, mism;
    logic [15:0] dc0;
    logic [7:0] expq[$];

    initial begin
        vt[0]  = '{68, 16'd26400, 8'h11, 8'h45, 1'b0, 1, 0, 0, 40, 0};
        vt[1]  = '{64, 16'd26400, 8'h11, 8'h45, 1'b0, 1, 0, 0, 36, 1};
        vt[2]  = '{68, 16'd26401, 8'h11, 8'h45, 1'b0, 0, 1, 2,  0, 0};
        vt[3]  = '{68, 16'd26400, 8'h06, 8'h45, 1'b0, 0, 1, 2,  0, 0};
        vt[4]  = '{16, 16'd26400, 8'h11, 8'h45, 1'b0, 0, 1, 1,  0, 0};
        vt[5]  = '{28, 16'd26400, 8'h11, 8'h45, 1'b0, 1, 1, 3,  0, 0};
        vt[6]  = '{68, 16'd26400, 8'h11, 8'h45, 1'b1, 1, 0, 0, 40, 0};
        vt[7]  = '{45, 16'd26400, 8'h11, 8'h45, 1'b0, 1, 0, 0, 17, 1};
        vt[8]  = '{68, 16'd26400, 8'h11, 8'h46, 1'b0, 0, 1, 2,  0, 0};
        vt[9]  = '{12, 16'd26400, 8'h11, 8'h45, 1'b0, 0, 1, 1,  0, 0};
        vt[10] = '{ 8, 16'd26400, 8'h11, 8'h45, 1'b0, 0, 1, 0,  0, 0};
        vt[11] = '{30, 16'd26400, 8'h11, 8'h45, 1'b0, 1, 0, 0,  2, 1};
        vt[12] = '{36, 16'd26400, 8'h11, 8'h45, 1'b1, 1, 0, 0,  8, 0};

        din = '0; din_keep = '0; din_valid = 1'b0; din_last = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {dout, dout_keep, dout_valid, dout_last, pkt_accept, pkt_drop},
            {64'h0, 8'h0, 4'h0});
        chk("reset_drop_count", 64'(drop_count), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 13; v++) begin
            ob0 = obytes.size(); acc0 = nacc; drop0 = ndrop; last0 = nlast; kb0 = keep_bad;
            dc0 = drop_count;
            build(vt[v].len, vt[v].port, vt[v].proto, vt[v].ver, v * 29);
            send(vt[v].len, vt[v].gap, 1'b1, 32);
            chk($sformatf("v%0d_accepts", v), 64'(nacc - acc0), 64'(vt[v].acc));
            chk($sformatf("v%0d_drops", v), 64'(ndrop - drop0), 64'(vt[v].drp));
            if (vt[v].acc != 0) chk($sformatf("v%0d_accept_cycle", v), 64'(acc_n), 64'(beat_n[2]));
            if (vt[v].drp != 0)
                chk($sformatf("v%0d_drop_cycle", v), 64'(drop_n), 64'(beat_n[vt[v].dbeat]));
            chk($sformatf("v%0d_nbytes", v), 64'(obytes.size() - ob0), 64'(vt[v].nbytes));
            mism = 0;
            for (int i = 0; i < vt[v].nbytes && ob0 + i < obytes.size(); i++)
                if (obytes[ob0+i] !== pkt[28+i]) mism++;
            chk($sformatf("v%0d_payload_mismatches", v), 64'(mism), 64'h0);
            chk($sformatf("v%0d_last_count", v), 64'(nlast - last0), 64'(vt[v].nbytes > 0 ? 1 : 0));
            if (vt[v].nbytes > 0)
                chk($sformatf("v%0d_last_cycle", v), 64'(last_out_n), 64'(last_in_n + vt[v].flush));
            chk($sformatf("v%0d_drop_count_delta", v), 64'(drop_count - dc0), 64'(vt[v].drp));
            chk($sformatf("v%0d_keep_contiguous", v), 64'(keep_bad - kb0), 64'h0);
        end

        // Back-to-back: flushing packet immediately followed by a valid packet
        ob0 = obytes.size(); acc0 = nacc; drop0 = ndrop; last0 = nlast;
        expq.delete();
        build(64, 16'd26400, 8'h11, 8'h45, 77);
        for (int i = 28; i < 64; i++) expq.push_back(pkt[i]);
        send(64, 1'b0, 1'b0, 32);
        build(68, 16'd26400, 8'h11, 8'h45, 91);
        for (int i = 28; i < 68; i++) expq.push_back(pkt[i]);
        send(68, 1'b0, 1'b1, 32);
        chk("b2b_nbytes", 64'(obytes.size() - ob0), 64'(expq.size()));
        mism = 0;
        for (int i = 0; i < expq.size() && ob0 + i < obytes.size(); i++)
            if (obytes[ob0+i] !== expq[i]) mism++;
        chk("b2b_payload_mismatches", 64'(mism), 64'h0);
        chk("b2b_last_count", 64'(nlast - last0), 64'd2);
        chk("b2b_accepts", 64'(nacc - acc0), 64'd2);
        chk("b2b_drops", 64'(ndrop - drop0), 64'd0);
        chk("b2b_second_accept_cycle", 64'(acc_n), 64'(beat_n[2]));

        // Reset in the middle of a payload
        build(68, 16'd26400, 8'h11, 8'h45, 5);
        send(68, 1'b0, 1'b0, 6);
        chk("midpkt_valid_before_reset", 64'(dout_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midpkt_async_reset_outputs",
            {dout, dout_keep, dout_valid, dout_last, pkt_accept, pkt_drop}, {64'h0, 8'h0, 4'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ob0 = obytes.size(); last0 = nlast; drop0 = ndrop;
        build(68, 16'd26400, 8'h11, 8'h45, 41);
        send(68, 1'b0, 1'b1, 32);
        chk("post_reset_nbytes", 64'(obytes.size() - ob0), 64'd40);
        mism = 0;
        for (int i = 0; i < 40 && ob0 + i < obytes.size(); i++)
            if (obytes[ob0+i] !== pkt[28+i]) mism++;
        chk("post_reset_payload_mismatches", 64'(mism), 64'h0);
        chk("post_reset_last_count", 64'(nlast - last0), 64'd1);
        chk("post_reset_drops", 64'(ndrop - drop0), 64'd0);
        chk("post_reset_drop_count", 64'(drop_count), 64'h0);

        // Drop counter saturation using single-beat runts every cycle
        din = '0; din_keep = 8'hFF; din_valid = 1'b1; din_last = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        din_valid = 1'b0; din_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("drop_count_fffe", 64'(drop_count), 64'hFFFE);
        din_valid = 1'b1; din_last = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        din_valid = 1'b0; din_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("drop_count_saturated", 64'(drop_count), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
